// File: rtl/des_key_sched_rev.sv
// DES round-key generator: emits K1..K16 (or K16..K1 for decryption) as 48-bit
// subkeys over a valid/ready handshake, one subkey per accepted transfer.
module des_key_sched_rev (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] key_in,
  input  logic        key_load,
  input  logic        decrypt,
  output logic [47:0] subkey_out,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  round_idx,
  output logic        busy,
  output logic        done
);

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  // Tables use DES bit numbering: entry n selects bit n, where bit 1 is the MSB.
  localparam int unsigned PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1_TAB[i]];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2_TAB[i]];
    return r;
  endfunction

  function automatic logic [27:0] rol28(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] ror28(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  // Rounds 1, 2, 9 and 16 shift by one; every other round shifts by two.
  function automatic logic shift_two(input logic [4:0] rnd);
    return !(rnd == 5'd1 || rnd == 5'd2 || rnd == 5'd9 || rnd == 5'd16);
  endfunction

  state_e      state_q, state_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [3:0]  count_q, count_d;
  logic        mode_q, mode_d;
  logic        done_q, done_d;

  logic [55:0] cd0;
  logic        xfer;
  logic [4:0]  rnd_enc, rnd_dec;
  logic        unused_parity;

  assign cd0     = pc1(key_in);
  assign xfer    = (state_q == ST_RUN) && subkey_ready;
  assign rnd_enc = {1'b0, count_q} + 5'd2;
  assign rnd_dec = 5'd16 - {1'b0, count_q};
  assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                           key_in[24], key_in[16], key_in[8], key_in[0]};

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    count_d = count_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_load) begin
          state_d = ST_RUN;
          mode_d  = decrypt;
          count_d = '0;
          if (decrypt) begin
            c_d = cd0[55:28];
            d_d = cd0[27:0];
          end else begin
            c_d = rol28(cd0[55:28], 1'b0);
            d_d = rol28(cd0[27:0], 1'b0);
          end
        end
      end
      ST_RUN: begin
        if (xfer) begin
          if (count_q == 4'd15) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            count_d = count_q + 4'd1;
            if (mode_q) begin
              c_d = ror28(c_q, shift_two(rnd_dec));
              d_d = ror28(d_q, shift_two(rnd_dec));
            end else begin
              c_d = rol28(c_q, shift_two(rnd_enc));
              d_d = rol28(d_q, shift_two(rnd_enc));
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    if (rst) begin
      state_q <= ST_IDLE;
      c_q     <= '0;
      d_q     <= '0;
      count_q <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  // Outputs decode purely from registers, so they are stable across the whole cycle.
  assign subkey_valid = (state_q == ST_RUN);
  assign busy         = (state_q == ST_RUN);
  assign done         = done_q;
  assign subkey_out   = subkey_valid ? pc2({c_q, d_q}) : '0;
  assign round_idx    = subkey_valid ? (mode_q ? 4'd15 - count_q : count_q) : '0;

endmodule

// File: tb/tb_des_key_sched_rev.sv
// Bench for des_key_sched_rev: vector table for whole schedules, scoreboard of
// expected subkeys checked on every transfer, plus stall/ignore/abort/chain sequences.
module tb_des_key_sched_rev;

  logic        clk;
  logic        rst;
  logic [63:0] key_in;
  logic        key_load;
  logic        decrypt;
  logic [47:0] subkey_out;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [3:0]  round_idx;
  logic        busy;
  logic        done;

  des_key_sched_rev dut (
    .clk          (clk),
    .rst          (rst),
    .key_in       (key_in),
    .key_load     (key_load),
    .decrypt      (decrypt),
    .subkey_out   (subkey_out),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .round_idx    (round_idx),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] k;
    logic [3:0]  idx;
  } exp_t;

  typedef struct {
    logic [63:0] key;
    logic        dec;
    int          sel;        // 0 = reference key schedule, 1 = all-zero schedule
    logic [47:0] exp_first;
    logic [3:0]  exp_first_idx;
  } vec_t;

  // Reference schedule K1..K16 for key 0x133457799BBCDFF1.
  logic [47:0] k_ref [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  exp_t sb_q [$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_done_seen = 0;
  int   n_done_exp = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] exp_key(input int sel, input int idx);
    return (sel == 1) ? 48'h0 : k_ref[idx];
  endfunction

  task automatic push_expected(input int sel, input logic dec);
    exp_t e;
    for (int r = 0; r < 16; r++) begin
      e.idx = dec ? 4'(15 - r) : 4'(r);
      e.k   = exp_key(sel, int'(e.idx));
      sb_q.push_back(e);
    end
  endtask

  // Every transfer (valid & ready, sampled mid-cycle) must match the scoreboard head.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && done) n_done_seen++;
    if (!rst && subkey_valid && subkey_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected transfer", 64'(subkey_out), 64'h0);
      end else begin
        e = sb_q.pop_front();
        check("subkey", 64'(subkey_out), 64'(e.k));
        check("round_idx", 64'(round_idx), 64'(e.idx));
      end
    end
  end

  task automatic start(input vec_t v);
    push_expected(v.sel, v.dec);
    key_in   = v.key;
    decrypt  = v.dec;
    key_load = 1'b1;
  endtask

  // Runs one schedule after start(); returns in the done cycle (or after an abort).
  task automatic run_body(input vec_t v, input int stall_idx, input int stall_len,
                          input int poke_idx, input int abort_idx);
    int cyc;
    bit stalled;
    bit poked;
    @(posedge clk); #1;
    key_load = 1'b0;
    key_in   = {$urandom, $urandom};
    decrypt  = ~decrypt;
    cyc      = 1;
    stalled  = 1'b0;
    poked    = 1'b0;
    check("first valid", 64'(subkey_valid), 64'h1);
    check("first busy", 64'(busy), 64'h1);
    check("first subkey", 64'(subkey_out), 64'(v.exp_first));
    check("first idx", 64'(round_idx), 64'(v.exp_first_idx));
    while (!done && cyc < 100) begin
      key_load = 1'b0;
      if (abort_idx >= 0 && subkey_valid && int'(round_idx) == abort_idx) begin
        #2 rst = 1'b1;
        #1;
        check("abort valid", 64'(subkey_valid), 64'h0);
        check("abort busy", 64'(busy), 64'h0);
        check("abort subkey", 64'(subkey_out), 64'h0);
        check("abort idx", 64'(round_idx), 64'h0);
        check("abort done", 64'(done), 64'h0);
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      if (stall_idx >= 0 && !stalled && subkey_valid && int'(round_idx) == stall_idx) begin
        stalled      = 1'b1;
        subkey_ready = 1'b0;
        repeat (stall_len) begin
          @(posedge clk); #1;
          cyc++;
          check("stall valid", 64'(subkey_valid), 64'h1);
          check("stall subkey", 64'(subkey_out), 64'(exp_key(v.sel, stall_idx)));
          check("stall idx", 64'(round_idx), 64'(stall_idx));
        end
        subkey_ready = 1'b1;
      end
      if (poke_idx >= 0 && !poked && subkey_valid && int'(round_idx) == poke_idx) begin
        poked    = 1'b1;
        key_load = 1'b1;
        key_in   = 64'h0123456789ABCDEF;
        decrypt  = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    key_load = 1'b0;
    check("done latency", 64'(cyc), 64'(17 + stall_len));
    check("scoreboard drained", 64'(sb_q.size()), 64'h0);
    check("done cycle valid", 64'(subkey_valid), 64'h0);
    check("done cycle busy", 64'(busy), 64'h0);
    n_done_exp++;
  endtask

  task automatic after_done();
    @(posedge clk); #1;
    check("done width", 64'(done), 64'h0);
    check("idle valid", 64'(subkey_valid), 64'h0);
    check("idle busy", 64'(busy), 64'h0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    vec_t vecs [4];
    vecs[0] = '{key: 64'h133457799BBCDFF1, dec: 1'b0, sel: 0,
                exp_first: 48'h1B02EFFC7072, exp_first_idx: 4'd0};
    vecs[1] = '{key: 64'h133457799BBCDFF1, dec: 1'b1, sel: 0,
                exp_first: 48'hCB3D8B0E17F5, exp_first_idx: 4'd15};
    vecs[2] = '{key: 64'h0, dec: 1'b0, sel: 1, exp_first: 48'h0, exp_first_idx: 4'd0};
    vecs[3] = '{key: 64'h0, dec: 1'b1, sel: 1, exp_first: 48'h0, exp_first_idx: 4'd15};

    rst          = 1'b1;
    key_in       = '0;
    key_load     = 1'b0;
    decrypt      = 1'b0;
    subkey_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset valid", 64'(subkey_valid), 64'h0);
    check("reset busy", 64'(busy), 64'h0);
    check("reset done", 64'(done), 64'h0);
    check("reset subkey", 64'(subkey_out), 64'h0);
    check("reset idx", 64'(round_idx), 64'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Plain forward and reverse schedules, consumer always ready.
    for (int i = 0; i < 2; i++) begin
      start(vecs[i]);
      run_body(vecs[i], -1, 0, -1, -1);
      after_done();
    end

    // Consumer stalls for five cycles on subkey index 3.
    start(vecs[0]);
    run_body(vecs[0], 3, 5, -1, -1);
    after_done();

    // A new key_load at index 7 must be ignored.
    start(vecs[0]);
    run_body(vecs[0], -1, 0, 7, -1);
    after_done();

    // Asynchronous reset at index 9, then a clean restart from K1.
    start(vecs[0]);
    run_body(vecs[0], -1, 0, -1, 9);
    @(posedge clk); #1;
    start(vecs[0]);
    run_body(vecs[0], -1, 0, -1, -1);
    after_done();

    // All-zero key; the second run is requested in the done cycle of the first.
    start(vecs[2]);
    run_body(vecs[2], -1, 0, -1, -1);
    start(vecs[3]);
    run_body(vecs[3], -1, 0, -1, -1);
    after_done();

    repeat (2) @(posedge clk);
    #1;
    check("done pulse count", 64'(n_done_seen), 64'(n_done_exp));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
